fpga_reset_sequencer: RTL and testbench



---
 rtl/fpga_reset_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fpga_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpga_reset_sequencer
// Function : Merges PLL lock loss and a host soft-reset strobe into one
//            conditioned reset request with a guaranteed minimum assertion
//            length. It reports soft-reset completion once downstream logic
//            has had ACK_DELAY cycles to leave reset.
// Options  : FPGA_RESET_SEQ_COUNT_EN - enables the saturating rst_count
//            sequence counter. When it is undefined, rst_count reads zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_reset_sequencer #(
    parameter logic RST_POL     = 1'b0,
    parameter int   SYNC_STAGES = 3,
    parameter int   LOCK_FILTER = 16,
    parameter int   MIN_ASSERT  = 32,
    parameter int   ACK_DELAY   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        soft_rst_req,
    output logic        rst_req_out,
    output logic        soft_rst_done,
    output logic        busy,
    output logic [1:0]  rst_cause,
    output logic [15:0] rst_count
);

    localparam int c_CNT_MAX = (MIN_ASSERT > ACK_DELAY) ? MIN_ASSERT : ACK_DELAY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_FILT_W  = $clog2(LOCK_FILTER + 1);

    localparam logic [c_CNT_W-1:0]  c_ASSERT_LAST = c_CNT_W'(MIN_ASSERT - 1);
    localparam logic [c_CNT_W-1:0]  c_ACK_LAST    = c_CNT_W'(ACK_DELAY - 1);
    localparam logic [c_FILT_W-1:0] c_FILT_FULL   = c_FILT_W'(LOCK_FILTER);

    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_FILT_W-1:0]    r_filt;
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_soft_pending;

    logic                   w_lock_sync;
    logic                   w_lock_ok;
    logic                   w_pll_trig;
    logic                   w_soft_trig;
    logic                   w_trig;
    logic [1:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_rst_req_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic [1:0]             w_cause_nxt;
    logic                   w_pending_nxt;

    // Shift the asynchronous PLL lock status through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_sync = r_sync[SYNC_STAGES-1];

    // Count consecutive synchronized-high cycles and saturate once lock is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= '0;
        end else if (!w_lock_sync) begin
            r_filt <= '0;
        end else if (r_filt != c_FILT_FULL) begin
            r_filt <= r_filt + 1'b1;
        end
    end

    // Lock drops in the same cycle the synchronized input goes low.
    // It does not wait for the filter counter to clear.
    assign w_lock_ok   = w_lock_sync && (r_filt == c_FILT_FULL);
    assign w_pll_trig  = !w_lock_ok;
    assign w_soft_trig = soft_rst_req;
    assign w_trig      = w_pll_trig || w_soft_trig;

    // State register and sequence counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ASSERT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. Any trigger restarts the assertion window from zero.
    // Reaching the last ASSERT count without a trigger always exits, so the
    // counter never needs to saturate explicitly.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_ASSERT: begin
                if (w_trig) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_ASSERT_LAST) begin
                    w_state_nxt = c_ST_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_RELEASE: begin
                if (w_trig) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_ACK_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_RUN: begin
                if (w_trig) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_ASSERT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state, so every output is a flop.
    always_comb begin
        w_rst_req_nxt = (w_state_nxt == c_ST_ASSERT) ? RST_POL : ~RST_POL;
        w_busy_nxt    = (w_state_nxt != c_ST_RUN);
        w_done_nxt    = (r_state == c_ST_RELEASE) && (w_state_nxt == c_ST_RUN) && r_soft_pending;
        w_cause_nxt   = w_trig ? {w_soft_trig, w_pll_trig} : rst_cause;
        // A PLL abort leaves the pending flag alone.
        // The soft request is still acknowledged after recovery.
        w_pending_nxt = w_soft_trig ? 1'b1 : (w_done_nxt ? 1'b0 : r_soft_pending);
    end

    // Output and pending-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_req_out    <= RST_POL;
            busy           <= 1'b1;
            soft_rst_done  <= 1'b0;
            rst_cause      <= 2'b00;
            r_soft_pending <= 1'b0;
        end else begin
            rst_req_out    <= w_rst_req_nxt;
            busy           <= w_busy_nxt;
            soft_rst_done  <= w_done_nxt;
            rst_cause      <= w_cause_nxt;
            r_soft_pending <= w_pending_nxt;
        end
    end

`ifdef FPGA_RESET_SEQ_COUNT_EN
    logic        w_enter_assert;
    logic [15:0] r_rst_count;

    // Count only fresh entries into ASSERT. Restarts within ASSERT are not counted.
    assign w_enter_assert = (r_state != c_ST_ASSERT) && (w_state_nxt == c_ST_ASSERT);

    // Saturating count of reset sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_count <= 16'h0000;
        end else if (w_enter_assert && (r_rst_count != 16'hFFFF)) begin
            r_rst_count <= r_rst_count + 16'd1;
        end
    end

    assign rst_count = r_rst_count;
`else
    assign rst_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpga_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_reset_sequencer
// Function : Directed bench for fpga_reset_sequencer. An age-since-last-
//            trigger model predicts every output each cycle. Literal
//            expectations at key cycles pin the model to the documented
//            latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_reset_sequencer;

    localparam int   P_SYNC = 3;
    localparam int   P_FILT = 16;
    localparam int   P_MIN  = 32;
    localparam int   P_ACK  = 16;
    localparam logic P_POL  = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b1;
    logic        soft_rst_req = 1'b0;
    logic        rst_req_out;
    logic        soft_rst_done;
    logic        busy;
    logic [1:0]  rst_cause;
    logic [15:0] rst_count;

    int n_vec = 0;
    int n_err = 0;

    fpga_reset_sequencer #(
        .RST_POL    (P_POL),
        .SYNC_STAGES(P_SYNC),
        .LOCK_FILTER(P_FILT),
        .MIN_ASSERT (P_MIN),
        .ACK_DELAY  (P_ACK)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_req_out  (rst_req_out),
        .soft_rst_done(soft_rst_done),
        .busy         (busy),
        .rst_cause    (rst_cause),
        .rst_count    (rst_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the whole sequence is a function of the age since the last
    // trigger cycle (age 1 = first cycle after the trigger or reset).
    //   age 1..MIN              : request asserted
    //   age MIN+1..MIN+ACK      : released, still busy
    //   age > MIN+ACK           : running
    // ------------------------------------------------------------------
    logic m_hist[$];
    int   m_run, m_age, m_cause, m_count;
    logic m_pend, m_done, m_ls, m_lok, m_trig;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_hist = {};
                for (int i = 0; i < P_SYNC; i++) m_hist.push_back(1'b0);
                m_run = 0; m_age = 1; m_cause = 0; m_count = 0;
                m_pend = 1'b0; m_done = 1'b0;
            end else begin
                m_ls = m_hist.pop_front();
                m_hist.push_back(pll_locked);
                m_lok = m_ls && (m_run >= P_FILT);
                m_run = m_ls ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
                m_trig = soft_rst_req || !m_lok;
                m_done = 1'b0;
                if (m_trig) begin
                    m_cause = {30'd0, soft_rst_req, !m_lok};
`ifdef FPGA_RESET_SEQ_COUNT_EN
                    if (m_age > P_MIN && m_count < 65535) m_count = m_count + 1;
`endif
                    if (soft_rst_req) m_pend = 1'b1;
                    m_age = 1;
                end else begin
                    if (m_age == P_MIN + P_ACK && m_pend) begin
                        m_done = 1'b1;
                        m_pend = 1'b0;
                    end
                    if (m_age < 100000) m_age = m_age + 1;
                end
            end
            #1;
            chk("model_rst_req_out", rst_req_out, (m_age <= P_MIN) ? P_POL : !P_POL);
            chk("model_busy", busy, (m_age <= P_MIN + P_ACK) ? 1 : 0);
            chk("model_soft_rst_done", soft_rst_done, m_done);
            chk("model_rst_cause", rst_cause, m_cause);
            chk("model_rst_count", rst_count, m_count);
        end
    end

    int ndone;
    int dpos;
    int exp_cnt;

    // Directed stimulus with literal expectations, sampled on the falling edge.
    initial begin
        // 1. Power-on with the PLL already locked.
        repeat (5) @(negedge clk);
        chk("por_req_asserted", rst_req_out, 0);
        chk("por_busy", busy, 1);
        chk("por_cause", rst_cause, 0);
        chk("por_done", soft_rst_done, 0);
        rst = 1'b0;                              // cycle R
        repeat (50) @(negedge clk);
        chk("por_req_at_R50", rst_req_out, 0);
        @(negedge clk);
        chk("por_release_R51", rst_req_out, 1);
        chk("por_busy_R51", busy, 1);
        repeat (15) @(negedge clk);
        chk("por_busy_R66", busy, 1);
        @(negedge clk);
        chk("por_idle_R67", busy, 0);
        chk("por_no_done", soft_rst_done, 0);
        chk("por_count", rst_count, 0);

        // 2. Soft reset from RUN.
        repeat (3) @(negedge clk);
        soft_rst_req = 1'b1;                     // cycle N
        @(negedge clk); soft_rst_req = 1'b0;
        chk("soft_req_N1", rst_req_out, 0);
        chk("soft_cause", rst_cause, 2);
        repeat (31) @(negedge clk);
        chk("soft_req_N32", rst_req_out, 0);
        @(negedge clk);
        chk("soft_release_N33", rst_req_out, 1);
        repeat (15) @(negedge clk);
        chk("soft_done_N48", soft_rst_done, 0);
        @(negedge clk);
        chk("soft_done_N49", soft_rst_done, 1);
        chk("soft_busy_N49", busy, 0);
        @(negedge clk);
        chk("soft_done_N50", soft_rst_done, 0);

        // 3. Two-cycle PLL glitch from RUN.
        repeat (2) @(negedge clk);
        pll_locked = 1'b0;                       // cycle D
        @(negedge clk);
        @(negedge clk); pll_locked = 1'b1;
        @(negedge clk);
        chk("pll_req_D3", rst_req_out, 1);
        @(negedge clk);
        chk("pll_req_D4", rst_req_out, 0);
        chk("pll_cause_D4", rst_cause, 1);
        repeat (48) @(negedge clk);
        chk("pll_req_D52", rst_req_out, 0);
        @(negedge clk);
        chk("pll_release_D53", rst_req_out, 1);
        repeat (16) @(negedge clk);
        chk("pll_idle_D69", busy, 0);
        chk("pll_no_done", soft_rst_done, 0);

        // 4. Second soft strobe five cycles into RELEASE aborts the sequence.
        repeat (2) @(negedge clk);
        soft_rst_req = 1'b1;                     // cycle N
        @(negedge clk); soft_rst_req = 1'b0;
        repeat (37) @(negedge clk);
        soft_rst_req = 1'b1;                     // cycle M = N+38
        @(negedge clk); soft_rst_req = 1'b0;
        chk("abort_req_M1", rst_req_out, 0);
        ndone = 0; dpos = 0;
        for (int i = 1; i <= 60; i++) begin
            if (soft_rst_done === 1'b1) begin
                ndone++;
                dpos = i;
            end
            if (i < 60) @(negedge clk);
        end
        chk("abort_done_count", ndone, 1);
        chk("abort_done_pos", dpos, 49);

        // 5. Soft strobe in the same cycle the synchronized lock drops.
        @(negedge clk); pll_locked = 1'b0;       // cycle D
        repeat (3) @(negedge clk);
        soft_rst_req = 1'b1;                     // D+3
        @(negedge clk); soft_rst_req = 1'b0;
        chk("both_cause_D4", rst_cause, 3);
        chk("both_req_D4", rst_req_out, 0);
        repeat (6) @(negedge clk);
        pll_locked = 1'b1;                       // D+10
        repeat (30) @(negedge clk);
        chk("both_req_D40", rst_req_out, 0);
        repeat (20) @(negedge clk);
        chk("both_req_D60", rst_req_out, 0);
        @(negedge clk);
        chk("both_release_D61", rst_req_out, 1);
        repeat (16) @(negedge clk);
        chk("both_done_D77", soft_rst_done, 1);

        // 6. Three soft sequences, then rst in the middle of ASSERT.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); soft_rst_req = 1'b1;
            @(negedge clk); soft_rst_req = 1'b0;
            repeat (50) @(negedge clk);
        end
`ifdef FPGA_RESET_SEQ_COUNT_EN
        exp_cnt = 8;
`else
        exp_cnt = 0;
`endif
        chk("count_after_soft", rst_count, exp_cnt);
        @(negedge clk); soft_rst_req = 1'b1;
        @(negedge clk); soft_rst_req = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", rst_req_out, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_cause", rst_cause, 0);
        chk("midrst_count", rst_count, 0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            if (soft_rst_done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("midrst_dropped_done", ndone, 0);
        chk("midrst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
